// File: rtl/ball_engine.sv
// ball_engine: pong ball motion, wall/paddle bounces, miss detection and life counting.
module ball_engine #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 64,
  parameter int STEP      = 1,
  parameter int LIVES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       paddle_hit,
  output logic       miss,
  output logic [1:0] lives,
  output logic       game_over
);
  localparam logic [10:0] W         = 11'(SCREEN_W);
  localparam logic [10:0] H         = 11'(SCREEN_H);
  localparam logic [10:0] BS        = 11'(BALL_SIZE);
  localparam logic [10:0] PW        = 11'(PADDLE_W);
  localparam logic [10:0] ST        = 11'(STEP);
  localparam logic [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] SERVE_OFF = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  X_RST     = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  typedef enum logic [1:0] {SERVE, MOVE, LOST, OVER} state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [1:0] lives_q, lives_d;
  logic       hit_q, hit_d, miss_q, miss_d, over_q;

  logic [10:0] bx, by, px, py, sx;
  logic [9:0]  serve_x, serve_y, step_x, step_y;
  logic        wall_x, wall_y, on_paddle, at_bottom;

  assign bx = {1'b0, x_q};
  assign by = {1'b0, y_q};
  assign px = {1'b0, paddle_x};
  assign py = {1'b0, paddle_y};
  assign sx = px + SERVE_OFF;
  assign serve_x = 10'(sx > X_MAX ? X_MAX : sx);
  assign serve_y = 10'(py >= BS ? py - BS : 11'd0);
  // dx_q/dy_q: 1 = right/up
  assign wall_x = dx_q ? (bx + BS + ST > W) : (bx < ST);
  assign step_x = 10'(wall_x ? (dx_q ? X_MAX : 11'd0) : (dx_q ? bx + ST : bx - ST));
  assign wall_y = dy_q & (by < ST);
  assign on_paddle = !dy_q && (by + BS <= py) && (by + BS + ST >= py) && (bx + BS > px) && (bx < px + PW);
  assign at_bottom = !dy_q && !on_paddle && (by + BS + ST >= H);
  assign step_y = 10'(dy_q ? (wall_y ? 11'd0 : by - ST) : (on_paddle ? py - BS : by + ST));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    lives_d = lives_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      SERVE: begin
        x_d = serve_x;
        y_d = serve_y;
        if (launch) begin
          state_d = MOVE;
          dx_d    = 1'b1;
          dy_d    = 1'b1;
        end
      end
      MOVE: begin
        if (tick && at_bottom) begin
          miss_d  = 1'b1;
          lives_d = lives_q - 2'd1;
          state_d = LOST;
        end else if (tick) begin
          x_d   = step_x;
          y_d   = step_y;
          dx_d  = dx_q ^ wall_x;
          dy_d  = dy_q ^ (wall_y | on_paddle);
          hit_d = on_paddle;
        end
      end
      LOST: state_d = tick ? (lives_q != 2'd0 ? SERVE : OVER) : LOST;
      OVER: begin
        if (launch) begin
          lives_d = LIVES_INIT;
          state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SERVE;
      x_q     <= X_RST;
      y_q     <= '0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      lives_q <= LIVES_INIT;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      over_q  <= state_d == OVER;
    end
  end

  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign paddle_hit = hit_q;
  assign miss       = miss_q;
  assign lives      = lives_q;
  assign game_over  = over_q;
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: scoreboarded cycle model of ball_engine plus scenario spot checks.
module tb_ball_engine;
  logic       clk = 1'b0;
  logic       rst, tick, launch;
  logic [9:0] paddle_x, paddle_y;
  logic [9:0] ball_x, ball_y;
  logic       paddle_hit, miss, game_over;
  logic [1:0] lives;

  int tests = 0;
  int fails = 0;
  int sb_prints = 0;

  typedef struct {int x; int y; int hit; int miss; int lives; int over;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int m_state, m_x, m_y, m_dx, m_dy, m_lives, m_hit, m_miss, m_over;

  ball_engine dut (
    .clk(clk), .rst(rst), .tick(tick), .launch(launch),
    .paddle_x(paddle_x), .paddle_y(paddle_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .paddle_hit(paddle_hit), .miss(miss), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_x = 316; m_y = 0; m_dx = 1; m_dy = 1;
    m_lives = 3; m_hit = 0; m_miss = 0; m_over = 0;
  endtask

  // Reference behaviour for default parameters (640x480, ball 8, paddle 64, step 1).
  task automatic model_step(input int t, input int l, input int px, input int py);
    int hp, bt;
    m_hit = 0;
    m_miss = 0;
    if (m_state == 0) begin
      m_x = (px + 28 > 632) ? 632 : px + 28;
      m_y = (py >= 8) ? py - 8 : 0;
      if (l != 0) begin m_state = 1; m_dx = 1; m_dy = 1; end
    end else if (m_state == 1) begin
      if (t != 0) begin
        hp = (m_dy == 0 && m_y + 8 <= py && m_y + 9 >= py && m_x + 8 > px && m_x < px + 64) ? 1 : 0;
        bt = (m_dy == 0 && hp == 0 && m_y + 9 >= 480) ? 1 : 0;
        if (bt != 0) begin
          m_miss = 1; m_lives = m_lives - 1; m_state = 2;
        end else begin
          if (m_dx != 0) begin
            if (m_x + 9 > 640) begin m_x = 632; m_dx = 0; end else m_x = m_x + 1;
          end else begin
            if (m_x < 1) begin m_x = 0; m_dx = 1; end else m_x = m_x - 1;
          end
          if (m_dy != 0) begin
            if (m_y < 1) begin m_y = 0; m_dy = 0; end else m_y = m_y - 1;
          end else if (hp != 0) begin
            m_y = py - 8; m_dy = 1; m_hit = 1;
          end else m_y = m_y + 1;
        end
      end
    end else if (m_state == 2) begin
      if (t != 0) m_state = (m_lives > 0) ? 0 : 3;
    end else if (l != 0) begin
      m_lives = 3; m_state = 0;
    end
    m_over = (m_state == 3) ? 1 : 0;
  endtask

  task automatic cyc(input logic t, input logic l);
    @(negedge clk);
    tick = t;
    launch = l;
    if (!rst) model_reset();
    else model_step(int'(t), int'(l), int'(paddle_x), int'(paddle_y));
    sb.push_back('{m_x, m_y, m_hit, m_miss, m_lives, m_over});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests++;
      if (int'(ball_x) !== mon_e.x || int'(ball_y) !== mon_e.y || int'(paddle_hit) !== mon_e.hit ||
          int'(miss) !== mon_e.miss || int'(lives) !== mon_e.lives || int'(game_over) !== mon_e.over) begin
        fails++;
        if (sb_prints < 20)
          $display("FAIL scoreboard t=%0t: got x=%0d y=%0d hit=%0b miss=%0b lives=%0d over=%0b, want x=%0d y=%0d hit=%0d miss=%0d lives=%0d over=%0d",
                   $time, ball_x, ball_y, paddle_hit, miss, lives, game_over,
                   mon_e.x, mon_e.y, mon_e.hit, mon_e.miss, mon_e.lives, mon_e.over);
        sb_prints++;
      end
    end
  end

  task automatic test_reset();
    repeat (2) cyc(1'b0, 1'b0);
    tests++;
    if (ball_x !== 10'd316 || ball_y !== 10'd0) begin
      fails++; $display("FAIL reset_pos: got (%0d,%0d) want (316,0)", ball_x, ball_y);
    end
    tests++;
    if (lives !== 2'd3 || paddle_hit !== 1'b0 || miss !== 1'b0 || game_over !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got lives=%0d hit=%0b miss=%0b over=%0b want 3 0 0 0", lives, paddle_hit, miss, game_over);
    end
  endtask

  task automatic test_serve_tracking();
    rst = 1'b1;
    repeat (10) cyc(1'b0, 1'b0);
    tests++;
    if (ball_x !== 10'd316 || ball_y !== 10'd288 || paddle_hit !== 1'b0 || miss !== 1'b0) begin
      fails++; $display("FAIL serve_track: got (%0d,%0d) hit=%0b miss=%0b want (316,288) 0 0", ball_x, ball_y, paddle_hit, miss);
    end
  endtask

  task automatic test_walls();
    cyc(1'b1, 1'b1);
    tests++;
    if (ball_x !== 10'd316 || ball_y !== 10'd288) begin
      fails++; $display("FAIL launch_no_step: got (%0d,%0d) want (316,288)", ball_x, ball_y);
    end
    repeat (288) cyc(1'b1, 1'b0);
    tests++;
    if (ball_x !== 10'd604 || ball_y !== 10'd0) begin
      fails++; $display("FAIL top_wall: got (%0d,%0d) want (604,0)", ball_x, ball_y);
    end
    repeat (28) cyc(1'b1, 1'b0);
    tests++;
    if (ball_x !== 10'd632 || ball_y !== 10'd27) begin
      fails++; $display("FAIL right_wall: got (%0d,%0d) want (632,27)", ball_x, ball_y);
    end
    repeat (2) cyc(1'b1, 1'b0);
    tests++;
    if (ball_x !== 10'd631 || ball_y !== 10'd29) begin
      fails++; $display("FAIL wall_turn: got (%0d,%0d) want (631,29)", ball_x, ball_y);
    end
  endtask

  task automatic test_paddle_bounce();
    bit seen = 1'b0;
    paddle_x = 10'd320;
    for (int i = 0; i < 600 && !seen; i++) begin
      cyc(1'b1, 1'b0);
      seen = paddle_hit;
    end
    tests++;
    if (!seen || ball_y !== 10'd288 || ball_x !== 10'd372) begin
      fails++; $display("FAIL paddle_bounce: got hit=%0b (%0d,%0d) want 1 (372,288)", seen, ball_x, ball_y);
    end
    cyc(1'b1, 1'b0);
    tests++;
    if (paddle_hit !== 1'b0 || ball_y !== 10'd287) begin
      fails++; $display("FAIL hit_single: got hit=%0b y=%0d want 0 287", paddle_hit, ball_y);
    end
  endtask

  task automatic test_miss_game_over();
    bit seen;
    paddle_x = 10'd0;
    for (int k = 2; k >= 0; k--) begin
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
        cyc(1'b1, 1'b0);
        seen = miss;
      end
      tests++;
      if (!seen || ball_y !== 10'd471 || int'(lives) !== k) begin
        fails++; $display("FAIL miss_%0d: got miss=%0b y=%0d lives=%0d want 1 471 %0d", k, seen, ball_y, lives, k);
      end
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      if (k > 0) begin
        cyc(1'b0, 1'b0);
        tests++;
        if (ball_x !== 10'd28 || ball_y !== 10'd288 || game_over !== 1'b0) begin
          fails++; $display("FAIL reserve_%0d: got (%0d,%0d) over=%0b want (28,288) 0", k, ball_x, ball_y, game_over);
        end
        cyc(1'b1, 1'b1);
      end
    end
    tests++;
    if (game_over !== 1'b1 || lives !== 2'd0) begin
      fails++; $display("FAIL game_over: got over=%0b lives=%0d want 1 0", game_over, lives);
    end
    repeat (5) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    tests++;
    if (game_over !== 1'b0 || lives !== 2'd3 || ball_y !== 10'd471) begin
      fails++; $display("FAIL restart: got over=%0b lives=%0d y=%0d want 0 3 471", game_over, lives, ball_y);
    end
  endtask

  task automatic test_corner();
    paddle_x = 10'd316;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (288) cyc(1'b1, 1'b0);
    tests++;
    if (ball_x !== 10'd632 || ball_y !== 10'd0) begin
      fails++; $display("FAIL corner_reach: got (%0d,%0d) want (632,0)", ball_x, ball_y);
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    tests++;
    if (ball_x !== 10'd631 || ball_y !== 10'd1 || paddle_hit !== 1'b0 || miss !== 1'b0) begin
      fails++; $display("FAIL corner_flip: got (%0d,%0d) hit=%0b miss=%0b want (631,1) 0 0", ball_x, ball_y, paddle_hit, miss);
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    paddle_x = 10'd320;
    for (int i = 0; i < 400 && !seen; i++) begin
      cyc(1'b1, 1'b0);
      seen = (ball_y == 10'd287);
    end
    tests++;
    if (!seen || ball_x !== 10'd345) begin
      fails++; $display("FAIL pre_reset: got seen=%0b x=%0d want 1 345", seen, ball_x);
    end
    @(negedge clk);
    tick = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    tests++;
    if (ball_x !== 10'd316 || ball_y !== 10'd0 || lives !== 2'd3 || paddle_hit !== 1'b0 || miss !== 1'b0 || game_over !== 1'b0) begin
      fails++; $display("FAIL async_reset: got (%0d,%0d) lives=%0d hit=%0b miss=%0b over=%0b want (316,0) 3 0 0 0",
                        ball_x, ball_y, lives, paddle_hit, miss, game_over);
    end
    repeat (3) cyc(1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    tests++;
    if (ball_x !== 10'd348 || ball_y !== 10'd288 || paddle_hit !== 1'b0) begin
      fails++; $display("FAIL post_reset_serve: got (%0d,%0d) hit=%0b want (348,288) 0", ball_x, ball_y, paddle_hit);
    end
  endtask

  initial begin
    rst = 1'b0;
    tick = 1'b0;
    launch = 1'b0;
    paddle_x = 10'd288;
    paddle_y = 10'd296;
    model_reset();
    test_reset();
    test_serve_tracking();
    test_walls();
    test_paddle_bounce();
    test_miss_game_over();
    test_corner();
    test_async_reset();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
